// File: rtl/rr_arbiter_hextobin.sv
// 16-way round-robin arbiter, hold limited to MAX_HOLD cycles; grant is registered, one cycle after req is sampled.
// No backpressure: a holder keeps the grant only while it requests, en is high and its hold budget lasts.
module rr_arbiter_hextobin #(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  grant_id,
    output logic        grant_valid
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

    state_t      state_q, state_d;
    logic [15:0] grant_q, grant_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [3:0]  cnt_q, cnt_d;

    logic [3:0]  cur_id;
    logic [3:0]  next_ptr;
    logic [15:0] pick_cur;
    logic [15:0] pick_next;

    // First set bit of r at or above p, wrapping 15 -> 0; returns one-hot or zero.
    function automatic logic [15:0] rr_pick(input logic [15:0] r, input logic [3:0] p);
        logic [15:0] g;
        logic        found;
        logic [3:0]  idx;
        g     = '0;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = p + 4'(i);
            if (!found && r[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [3:0] onehot_to_bin(input logic [15:0] g);
        logic [3:0] id;
        id = '0;
        for (int i = 0; i < 16; i++) begin
            if (g[i]) id = id | 4'(i);
        end
        return id;
    endfunction

    assign cur_id    = onehot_to_bin(grant_q);
    assign next_ptr  = cur_id + 4'd1;
    assign pick_cur  = rr_pick(req, ptr_q);
    assign pick_next = rr_pick(req, next_ptr);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                cnt_d   = '0;
                if (en && (|req)) begin
                    state_d = GRANT;
                    grant_d = pick_cur;
                    cnt_d   = 4'd1;
                end
            end
            GRANT: begin
                if (!en) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = next_ptr;
                end else if (!req[cur_id] || (cnt_q >= MAX_HOLD_C)) begin
                    // Release and re-arbitrate from the advanced pointer in the same edge.
                    ptr_d = next_ptr;
                    if (|req) begin
                        grant_d = pick_next;
                        cnt_d   = 4'd1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = cur_id;
    assign grant_valid = |grant_q;

endmodule

// File: tb/tb_rr_arbiter_hextobin.sv
// Bench for rr_arbiter_hextobin (MAX_HOLD=4): vector table plus reset, wrap and full round-robin sequences.
module tb_rr_arbiter_hextobin;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  grant_id;
    logic        grant_valid;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        en;
        logic [15:0] req;
        logic        vld;
        logic [3:0]  id;
    } vec_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] id;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[30];

    always #5 clk = ~clk;

    rr_arbiter_hextobin #(.MAX_HOLD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .grant      (grant),
        .grant_id   (grant_id),
        .grant_valid(grant_valid)
    );

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic check_outputs(input string tag);
        exp_t        e;
        logic [15:0] eg;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got grant %h want entry", tag, grant);
            return;
        end
        e  = sb_q.pop_front();
        eg = e.vld ? (16'h0001 << e.id) : 16'h0000;
        cmp({tag, " grant"}, grant, eg);
        cmp({tag, " grant_id"}, {12'h0, grant_id}, {12'h0, e.id});
        cmp({tag, " grant_valid"}, {15'h0, grant_valid}, {15'h0, e.vld});
    endtask

    task automatic step(input string tag, input logic en_v, input logic [15:0] req_v,
                        input logic vld_v, input logic [3:0] id_v);
        en  = en_v;
        req = req_v;
        sb_q.push_back('{vld: vld_v, id: id_v});
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        // {en, req, expected valid, expected id}; starts from IDLE with ptr=0.
        tbl[0]  = '{1'b1, 16'h0000, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 16'hFFFF, 1'b0, 4'd0};
        tbl[2]  = '{1'b1, 16'h0100, 1'b1, 4'd8};
        tbl[3]  = '{1'b1, 16'h0100, 1'b1, 4'd8};
        tbl[4]  = '{1'b1, 16'h0100, 1'b1, 4'd8};
        tbl[5]  = '{1'b1, 16'h0100, 1'b1, 4'd8};
        tbl[6]  = '{1'b1, 16'h0100, 1'b1, 4'd8};
        tbl[7]  = '{1'b1, 16'h0100, 1'b1, 4'd8};
        tbl[8]  = '{1'b1, 16'h0000, 1'b0, 4'd0};
        tbl[9]  = '{1'b1, 16'h8001, 1'b1, 4'd15};
        tbl[10] = '{1'b1, 16'h8001, 1'b1, 4'd15};
        tbl[11] = '{1'b1, 16'h8001, 1'b1, 4'd15};
        tbl[12] = '{1'b1, 16'h8001, 1'b1, 4'd15};
        tbl[13] = '{1'b1, 16'h8001, 1'b1, 4'd0};
        tbl[14] = '{1'b1, 16'h8001, 1'b1, 4'd0};
        tbl[15] = '{1'b1, 16'h8001, 1'b1, 4'd0};
        tbl[16] = '{1'b1, 16'h8001, 1'b1, 4'd0};
        tbl[17] = '{1'b1, 16'h8001, 1'b1, 4'd15};
        tbl[18] = '{1'b1, 16'h8028, 1'b1, 4'd15};
        tbl[19] = '{1'b1, 16'h0028, 1'b1, 4'd3};
        tbl[20] = '{1'b1, 16'h0028, 1'b1, 4'd3};
        tbl[21] = '{1'b1, 16'h0020, 1'b1, 4'd5};
        tbl[22] = '{1'b1, 16'h0024, 1'b1, 4'd5};
        tbl[23] = '{1'b1, 16'h0004, 1'b1, 4'd2};
        tbl[24] = '{1'b0, 16'hFFFF, 1'b0, 4'd0};
        tbl[25] = '{1'b1, 16'hFFFF, 1'b1, 4'd3};
        tbl[26] = '{1'b1, 16'hFFFF, 1'b1, 4'd3};
        tbl[27] = '{1'b1, 16'hFFFF, 1'b1, 4'd3};
        tbl[28] = '{1'b1, 16'hFFFF, 1'b1, 4'd3};
        tbl[29] = '{1'b1, 16'hFFFF, 1'b1, 4'd4};

        rst = 1'b1;
        en  = 1'b0;
        req = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        cmp("reset grant", grant, 16'h0000);
        cmp("reset grant_id", {12'h0, grant_id}, 16'h0000);
        cmp("reset grant_valid", {15'h0, grant_valid}, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < 30; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].en, tbl[i].req, tbl[i].vld, tbl[i].id);
        end

        // Asynchronous reset during a grant of id 5.
        step("rst_pre", 1'b1, 16'h0020, 1'b1, 4'd5);
        rst = 1'b1;
        #1;
        cmp("async_rst grant", grant, 16'h0000);
        cmp("async_rst grant_id", {12'h0, grant_id}, 16'h0000);
        cmp("async_rst grant_valid", {15'h0, grant_valid}, 16'h0000);
        @(posedge clk);
        #1;
        cmp("rst_held grant", grant, 16'h0000);
        rst = 1'b0;
        step("rst_post", 1'b1, 16'h0001, 1'b1, 4'd0);

        // Full round robin from a fresh reset: each requester holds for 4 cycles.
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k <= 64; k++) begin
            step($sformatf("rr%0d", k), 1'b1, 16'hFFFF, 1'b1, 4'((k / 4) % 16));
        end

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_hextobin.md
RR_ARBITER_HEXTOBIN -- requirements
Module: rr_arbiter_hextobin

Interface
REQ-001 Parameter MAX_HOLD, default 4, legal range 1..15: maximum consecutive cycles one requester holds the grant.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  arbitration enable; low forces release and blocks new grants.
REQ-005 req  input  16  request vector; bit i is requester i.
REQ-006 grant  output  16  registered grant; one-hot or zero.
REQ-007 grant_id  output  4  binary index of the set bit of grant (hex-to-binary encoding); 4'd0 when grant is zero.
REQ-008 grant_valid  output  1  high exactly when grant is non-zero.

Function
REQ-009 State machine SHALL have two states: IDLE (grant=0) and GRANT (one grant bit set).
REQ-010 Internal state SHALL be a 4-bit round-robin pointer ptr and a 4-bit hold counter cnt.
REQ-011 Selection: search req from bit ptr upward, modulo 16 (15 wraps to 0); the first set bit wins.
REQ-012 IDLE: if en=1 and req!=0 at a rising edge, move to GRANT at that edge with the selected requester; latency is one cycle from sampled req to grant.
REQ-013 IDLE: if en=0 or req=0, stay in IDLE with grant=0.
REQ-014 Entering GRANT, or re-granting, SHALL load cnt=1; each further held cycle increments cnt.
REQ-015 GRANT hold: keep the grant while req[grant_id]=1, en=1 and cnt<MAX_HOLD.
REQ-016 GRANT release triggers: req[grant_id]=0, or cnt==MAX_HOLD; the grant therefore lasts at most MAX_HOLD cycles.
REQ-017 On release, set ptr=grant_id+1 modulo 16 and run the selection from the new ptr at the same edge.
REQ-018 Release with any req bit set and en=1: grant the selected requester at that edge with no idle bubble. This includes re-granting the same requester when it is the only one requesting.
REQ-019 Release with req=0: go to IDLE at that edge; grant=0.
REQ-020 en=0 sampled in GRANT: release at that edge, set ptr=grant_id+1, go to IDLE.
REQ-021 Simultaneous requests: exactly one grant bit is set, chosen by REQ-011; never more than one bit.
REQ-022 grant_id and grant_valid SHALL be consistent with grant every cycle (registered together or decoded combinationally from grant).
REQ-023 Requests arriving mid-grant SHALL NOT pre-empt the current holder.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force: grant=16'h0000, grant_id=4'd0, grant_valid=0, ptr=0, cnt=0, state IDLE.
REQ-025 Reset mid-grant SHALL discard the grant and restore ptr=0.
REQ-026 The first arbitration after rst deasserts occurs at the first rising edge with rst=0.

Verification
REQ-027 Reset check: assert rst during a grant of id 5 -> grant=0, valid=0, id=0 without waiting for a clock edge. Release rst with req=16'h0001 -> grant=16'h0001, id=0 after one edge.
REQ-028 Hold limit check (MAX_HOLD=4): req=16'h0100 held -> grant=16'h0100, id=8 stays continuously high (re-granted every 4 cycles, cnt reloads to 1), valid never drops.
REQ-029 Round robin check: req=16'hFFFF held -> grant_id sequence 0,1,2,...,15,0, each held 4 cycles, one-hot each cycle.
REQ-030 Wrap-around check: after a grant to id 15 releases (ptr=0), req=16'h8001 -> grant id 0 for 4 cycles, then id 15.
REQ-031 Early drop check: id 3 granted, req[3] drops after 2 grant cycles with req[5]=1 -> grant moves to 16'h0020 (id 5) at the next edge, no idle cycle.
REQ-032 Enable check: en=0 during a grant of id 2 -> grant=0 at the next edge. en=1 with req=16'hFFFF -> next grant is id 3.
